// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART APB two-master arbiter.
// Contents:
//   TIMEOUT_DEFAULT : default maximum number of slave ACCESS cycles (0 disables)
//   arb_state_e     : arbiter FSM states
//   mst_idx_t       : index of a master port (0 = CPU, 1 = DMA/boot sequencer)
//   idx_to_onehot   : converts a master index into a 2-bit one-hot grant
package uart_arb_pkg;

  localparam int TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } arb_state_e;

  typedef logic mst_idx_t;

  function automatic logic [1:0] idx_to_onehot(input mst_idx_t idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/uart_arb_rr_pick.sv
// Two-way round-robin picker, purely combinational.
// Ports:
//   req        : request vector, bit k = master k wants the slave
//   last_grant : index of the master served most recently
//   gnt        : one-hot winner (00 when nobody requests)
//   valid      : at least one request present
module uart_arb_rr_pick
  import uart_arb_pkg::*;
(
  input  logic [1:0] req,
  input  mst_idx_t   last_grant,
  output logic [1:0] gnt,
  output logic       valid
);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    gnt = req;
    // On a tie the master that was not served last wins.
    if (req == 2'b11) begin
      gnt = idx_to_onehot(~last_grant);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/uart_apb_arbiter.sv
// Two-master APB arbiter in front of the UART APB slave register port.
// Master 0 is the CPU, master 1 the DMA/boot sequencer. The granted transfer is
// replayed on the slave side with clean SETUP/ACCESS phasing; the response goes
// back only to the granted master. A hung slave is cut off after TIMEOUT ACCESS
// cycles with an error response (TIMEOUT = 0 disables this).
// Ports:
//   pclk_i, prst_ni                 : clock, asynchronous active-low reset
//   m{0,1}_psel/penable/pwrite_i    : master APB control
//   m{0,1}_paddr_i, m{0,1}_pwdata_i : master address and write data
//   m{0,1}_prdata_o/pready_o/pslverr_o : master response
//   s_psel/penable/pwrite_o, s_paddr_o, s_pwdata_o : slave request
//   s_prdata_i, s_pready_i, s_pslverr_i            : slave response
//   grant_o                         : one-hot owner of the current transfer, 00 when idle
module uart_apb_arbiter
  import uart_arb_pkg::*;
#(
  parameter int AW      = 12,
  parameter int DW      = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          pclk_i,
  input  logic          prst_ni,
  input  logic          m0_psel_i,
  input  logic          m0_penable_i,
  input  logic          m0_pwrite_i,
  input  logic [AW-1:0] m0_paddr_i,
  input  logic [DW-1:0] m0_pwdata_i,
  output logic [DW-1:0] m0_prdata_o,
  output logic          m0_pready_o,
  output logic          m0_pslverr_o,
  input  logic          m1_psel_i,
  input  logic          m1_penable_i,
  input  logic          m1_pwrite_i,
  input  logic [AW-1:0] m1_paddr_i,
  input  logic [DW-1:0] m1_pwdata_i,
  output logic [DW-1:0] m1_prdata_o,
  output logic          m1_pready_o,
  output logic          m1_pslverr_o,
  output logic          s_psel_o,
  output logic          s_penable_o,
  output logic          s_pwrite_o,
  output logic [AW-1:0] s_paddr_o,
  output logic [DW-1:0] s_pwdata_o,
  input  logic [DW-1:0] s_prdata_i,
  input  logic          s_pready_i,
  input  logic          s_pslverr_i,
  output logic [1:0]    grant_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_e    state;
  mst_idx_t      last_grant;
  logic [CW-1:0] count;

  logic [1:0]    pick_gnt;
  logic          pick_valid;
  logic          win_write;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
  logic          tmo_hit;
  logic          done;
  logic          timed_out;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  // A request counts in either APB phase, so penable carries no information here.
  logic unused_penable;
  assign unused_penable = m0_penable_i ^ m1_penable_i;

  uart_arb_rr_pick u_pick (
    .req        ({m1_psel_i, m0_psel_i}),
    .last_grant (last_grant),
    .gnt        (pick_gnt),
    .valid      (pick_valid)
  );

  always_comb begin
    win_write = m0_pwrite_i;
    win_addr  = m0_paddr_i;
    win_wdata = m0_pwdata_i;
    if (pick_gnt[1]) begin
      win_write = m1_pwrite_i;
      win_addr  = m1_paddr_i;
      win_wdata = m1_pwdata_i;
    end
  end

  // The counter holds the number of ACCESS cycles already spent, so the
  // TIMEOUT-th ACCESS cycle is the one where it equals TIMEOUT-1.
  assign tmo_hit   = (TIMEOUT != 0) && (count == CW'(TIMEOUT - 1));
  assign done      = (state == ACCESS) && (s_pready_i || tmo_hit);
  // A real slave response in the last allowed cycle beats the timeout.
  assign timed_out = done && !s_pready_i;
  assign rsp_rdata = timed_out ? '0 : s_prdata_i;
  assign rsp_err   = timed_out | s_pslverr_i;

  // The response is steered only to the granted master; the other sees zeros.
  always_comb begin
    m0_pready_o  = done && grant_o[0];
    m1_pready_o  = done && grant_o[1];
    m0_prdata_o  = m0_pready_o ? rsp_rdata : '0;
    m1_prdata_o  = m1_pready_o ? rsp_rdata : '0;
    m0_pslverr_o = m0_pready_o && rsp_err;
    m1_pslverr_o = m1_pready_o && rsp_err;
  end

  // Address, data and write are only reloaded on a new grant, so they stay
  // stable from SETUP through completion and linger unchanged in IDLE.
  always_ff @(posedge pclk_i or negedge prst_ni) begin
    if (!prst_ni) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      grant_o     <= 2'b00;
      count       <= '0;
      s_psel_o    <= 1'b0;
      s_penable_o <= 1'b0;
      s_pwrite_o  <= 1'b0;
      s_paddr_o   <= '0;
      s_pwdata_o  <= '0;
    end else begin
      // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_o    <= pick_gnt;
            s_pwrite_o <= win_write;
            s_paddr_o  <= win_addr;
            s_pwdata_o <= win_wdata;
            s_psel_o   <= 1'b1;
            state      <= SETUP;
          end
        end
        SETUP: begin
          s_penable_o <= 1'b1;
          state       <= ACCESS;
        end
        ACCESS: begin
          if (done) begin
            last_grant  <= grant_o[1];
            grant_o     <= 2'b00;
            count       <= '0;
            s_psel_o    <= 1'b0;
            s_penable_o <= 1'b0;
            state       <= IDLE;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_apb_arbiter.sv
// Self-checking bench for uart_apb_arbiter. A transaction-level model tracks
// which master owns the slave and how many cycles it has held it; expected
// outputs are derived from that each cycle and compared on the falling edge.
module tb_uart_apb_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TO = 4;

  logic pclk = 1'b0;
  logic prst_ni = 1'b0;
  always #5 pclk = ~pclk;

  logic          d_psel[2];
  logic          d_penable[2];
  logic          d_pwrite[2];
  logic [AW-1:0] d_paddr[2];
  logic [DW-1:0] d_pwdata[2];

  logic [DW-1:0] m0_prdata, m1_prdata;
  logic          m0_pready, m1_pready, m0_pslverr, m1_pslverr;
  logic          s_psel, s_penable, s_pwrite;
  logic [AW-1:0] s_paddr;
  logic [DW-1:0] s_pwdata;
  logic [DW-1:0] s_prdata;
  logic          s_pready, s_pslverr;
  logic [1:0]    grant;

  uart_apb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .pclk_i       (pclk),
    .prst_ni      (prst_ni),
    .m0_psel_i    (d_psel[0]),
    .m0_penable_i (d_penable[0]),
    .m0_pwrite_i  (d_pwrite[0]),
    .m0_paddr_i   (d_paddr[0]),
    .m0_pwdata_i  (d_pwdata[0]),
    .m0_prdata_o  (m0_prdata),
    .m0_pready_o  (m0_pready),
    .m0_pslverr_o (m0_pslverr),
    .m1_psel_i    (d_psel[1]),
    .m1_penable_i (d_penable[1]),
    .m1_pwrite_i  (d_pwrite[1]),
    .m1_paddr_i   (d_paddr[1]),
    .m1_pwdata_i  (d_pwdata[1]),
    .m1_prdata_o  (m1_prdata),
    .m1_pready_o  (m1_pready),
    .m1_pslverr_o (m1_pslverr),
    .s_psel_o     (s_psel),
    .s_penable_o  (s_penable),
    .s_pwrite_o   (s_pwrite),
    .s_paddr_o    (s_paddr),
    .s_pwdata_o   (s_pwdata),
    .s_prdata_i   (s_prdata),
    .s_pready_i   (s_pready),
    .s_pslverr_i  (s_pslverr),
    .grant_o      (grant)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: ownership plus cycles since grant (0 = setup, n>=1 = n-th access).
  bit            busy;
  int            owner, age, last_g, cyc;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic          l_write;
  int            cur_wait;
  logic [DW-1:0] cur_rd;
  logic          cur_err;

  // Staged and in-flight master transactions; slave behaviour travels with them.
  bit            want[2];
  bit            rep[2];
  logic [AW-1:0] st_addr[2];
  logic [DW-1:0] st_wdata[2];
  logic          st_write[2];
  int            st_wait[2];
  logic [DW-1:0] st_rd[2];
  logic          st_err[2];
  int            tx_wait[2];
  logic [DW-1:0] tx_rd[2];
  logic          tx_err[2];
  int            start_cyc[2];
  int            last_lat[2];
  logic          last_tmo[2];
  int            order[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    busy = 0; owner = 0; age = 0; last_g = 1;
    l_addr = '0; l_wdata = '0; l_write = 1'b0;
    for (int k = 0; k < 2; k++) begin
      d_psel[k] = 1'b0; d_penable[k] = 1'b0; want[k] = 0; rep[k] = 0;
    end
  endtask

  task automatic stage(input int k, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic w, input int wt, input logic [DW-1:0] rd, input logic er);
    st_addr[k] = a; st_wdata[k] = wd; st_write[k] = w;
    st_wait[k] = wt; st_rd[k] = rd; st_err[k] = er;
    want[k] = 1;
  endtask

  task automatic drive_slave();
    if (busy && age >= 1) begin
      s_pready  = (age - 1) >= cur_wait;
      s_prdata  = cur_rd;
      s_pslverr = cur_err;
    end else begin
      s_pready  = 1'($urandom_range(0, 1));
      s_prdata  = $urandom;
      s_pslverr = 1'($urandom_range(0, 1));
    end
  endtask

  // One clock cycle: check on the falling edge, then advance model and drivers after the rising edge.
  task automatic tick();
    logic          done, tmo;
    logic          e_rdy[2], e_err[2];
    logic [DW-1:0] e_rd[2];
    logic [1:0]    e_gnt;
    int            d_own;
    @(negedge pclk);
    done = busy && age >= 1 && (s_pready || (TO != 0 && age == TO));
    tmo  = done && !s_pready;
    for (int k = 0; k < 2; k++) begin
      e_rdy[k] = done && owner == k;
      e_rd[k]  = (e_rdy[k] && !tmo) ? s_prdata : '0;
      e_err[k] = e_rdy[k] && (tmo || s_pslverr);
    end
    e_gnt = !busy ? 2'b00 : (owner == 1 ? 2'b10 : 2'b01);
    check("grant", grant, e_gnt);
    check("s_ctl", {s_psel, s_penable, s_pwrite}, {busy, (busy && age >= 1), l_write});
    check("s_paddr", s_paddr, l_addr);
    check("s_pwdata", s_pwdata, l_wdata);
    check("m0_rsp", {m0_pready, m0_pslverr}, {e_rdy[0], e_err[0]});
    check("m0_prdata", m0_prdata, e_rd[0]);
    check("m1_rsp", {m1_pready, m1_pslverr}, {e_rdy[1], e_err[1]});
    check("m1_prdata", m1_prdata, e_rd[1]);
    d_own = owner;
    if (done) begin
      last_lat[owner] = cyc - start_cyc[owner];
      last_tmo[owner] = tmo;
      order.push_back(owner);
    end
    @(posedge pclk);
    #1;
    cyc++;
    if (prst_ni) begin
      if (!busy) begin
        if (d_psel[0] || d_psel[1]) begin
          owner = (d_psel[0] && d_psel[1]) ? 1 - last_g : (d_psel[1] ? 1 : 0);
          busy = 1; age = 0;
          l_addr = d_paddr[owner]; l_wdata = d_pwdata[owner]; l_write = d_pwrite[owner];
          cur_wait = tx_wait[owner]; cur_rd = tx_rd[owner]; cur_err = tx_err[owner];
        end
      end else if (age == 0) begin
        age = 1;
      end else if (done) begin
        busy = 0; last_g = owner; age = 0;
      end else begin
        age++;
      end
      for (int k = 0; k < 2; k++) begin
        if (done && d_own == k) begin
          d_psel[k] = 1'b0; d_penable[k] = 1'b0;
        end else if (d_psel[k]) begin
          d_penable[k] = 1'b1;
        end
        if (!d_psel[k] && want[k] && !(busy && owner == k)) begin
          d_psel[k] = 1'b1; d_penable[k] = 1'b0;
          d_paddr[k] = st_addr[k]; d_pwdata[k] = st_wdata[k]; d_pwrite[k] = st_write[k];
          tx_wait[k] = st_wait[k]; tx_rd[k] = st_rd[k]; tx_err[k] = st_err[k];
          start_cyc[k] = cyc;
          if (rep[k]) begin
            st_addr[k] = st_addr[k] + AW'(4);
            st_wdata[k] = $urandom;
          end else begin
            want[k] = 0;
          end
        end
      end
    end
    drive_slave();
  endtask

  task automatic run_idle(input int max);
    int n = 0;
    while ((busy || want[0] || want[1] || d_psel[0] || d_psel[1]) && n < max) begin
      tick();
      n++;
    end
    check("drain_in_budget", (n < max), 1);
  endtask

  task automatic do_reset();
    prst_ni = 1'b0;
    model_reset();
    tick();
    prst_ni = 1'b1;
  endtask

  initial begin
    int base, idx, n;
    for (int k = 0; k < 2; k++) begin
      d_pwrite[k] = 1'b0; d_paddr[k] = '0; d_pwdata[k] = '0;
      tx_wait[k] = 0; tx_rd[k] = '0; tx_err[k] = 1'b0;
      start_cyc[k] = 0; last_lat[k] = 0; last_tmo[k] = 1'b0;
    end
    cyc = 0; cur_wait = 0; cur_rd = '0; cur_err = 1'b0;
    model_reset();
    drive_slave();
    tick();
    tick();
    prst_ni = 1'b1;

    // Single m0 write with a zero-wait slave: pready two cycles after psel is sampled.
    stage(0, 12'h004, 32'h0000_00A5, 1'b1, 0, 32'h0, 1'b0);
    run_idle(20);
    check("t1_latency", last_lat[0], 2);

    // Simultaneous reads right after reset: m0 first, then m1, each with its own data.
    do_reset();
    base = order.size();
    stage(0, 12'h010, 32'h0, 1'b0, 0, 32'h11, 1'b0);
    stage(1, 12'h020, 32'h0, 1'b0, 0, 32'h22, 1'b0);
    run_idle(20);
    check("t2_count", order.size() - base, 2);
    if (order.size() >= base + 2) begin
      check("t2_first", order[base], 0);
      check("t2_second", order[base + 1], 1);
    end

    // m0 streams continuously while m1 asks once: grants alternate around m1.
    base = order.size();
    rep[0] = 1;
    stage(0, 12'h100, $urandom, 1'b1, 0, $urandom, 1'b0);
    tick();
    tick();
    stage(1, 12'h200, $urandom, 1'b1, 0, $urandom, 1'b0);
    for (int i = 0; i < 12; i++) tick();
    rep[0] = 0;
    want[0] = 0;
    run_idle(30);
    check("t3_m1_lat_le6", (last_lat[1] <= 6), 1);
    idx = -1;
    for (int i = base; i < order.size(); i++) if (order[i] == 1 && idx < 0) idx = i;
    check("t3_m1_after_m0", (idx > base), 1);
    if (idx > base && idx + 1 < order.size()) begin
      check("t3_prev_m0", order[idx - 1], 0);
      check("t3_next_m0", order[idx + 1], 0);
    end

    // Slave waits three ACCESS cycles, then responds with an error.
    stage(0, 12'h008, $urandom, 1'b0, 3, 32'hCAFE_0001, 1'b1);
    run_idle(20);
    check("t4_latency", last_lat[0], 5);
    check("t4_not_timeout", last_tmo[0], 1'b0);

    // Stuck slave: timeout fires in the 4th ACCESS cycle.
    stage(0, 12'h00C, $urandom, 1'b0, 100, 32'hDEAD_BEEF, 1'b0);
    run_idle(20);
    check("t5_latency", last_lat[0], 5);
    check("t5_timeout", last_tmo[0], 1'b1);

    // Granted master drops psel while waiting; the slave transfer still completes.
    stage(1, 12'h014, $urandom, 1'b1, 2, $urandom, 1'b0);
    n = 0;
    while (!(busy && owner == 1 && age >= 1) && n < 10) begin tick(); n++; end
    check("t6_grant_reached", (n < 10), 1);
    d_psel[1] = 1'b0;
    d_penable[1] = 1'b0;
    run_idle(20);
    check("t6_latency", last_lat[1], 4);

    // Reset asserted in ACCESS while the response is being returned.
    stage(1, 12'h018, $urandom, 1'b0, 0, 32'h5A5A_5A5A, 1'b0);
    n = 0;
    while (!(busy && age >= 1) && n < 10) begin tick(); n++; end
    check("t7_access_reached", (n < 10), 1);
    #2;
    check("t7_pre_rst_pready", m1_pready, 1'b1);
    prst_ni = 1'b0;
    #1;
    check("t7_rst_grant", grant, 2'b00);
    check("t7_rst_s_ctl", {s_psel, s_penable, s_pwrite}, 3'b000);
    check("t7_rst_s_paddr", s_paddr, 0);
    check("t7_rst_m1", {m1_pready, m1_pslverr, m1_prdata}, 0);
    model_reset();
    tick();
    prst_ni = 1'b1;
    base = order.size();
    stage(0, 12'h01C, $urandom, 1'b1, 0, $urandom, 1'b0);
    stage(1, 12'h01C, $urandom, 1'b1, 0, $urandom, 1'b0);
    run_idle(20);
    if (order.size() > base) check("t7_tie_after_rst", order[base], 0);
    else check("t7_tie_served", order.size() - base, 2);

    // Randomized traffic, including slave waits long enough to trip the timeout.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!want[k] && !d_psel[k] && $urandom_range(0, 2) == 0)
          stage(k, AW'($urandom), $urandom, 1'($urandom_range(0, 1)),
                $urandom_range(0, 5), $urandom, 1'($urandom_range(0, 1)));
      end
      tick();
    end
    run_idle(100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_apb_arbiter.md
Name: uart_apb_arbiter

Overview:
- Two-master APB arbiter placed in front of the UART APB slave, so the CPU (master 0) and the DMA/boot sequencer (master 1) can share one UART register port.
- Each master sees a standard APB slave that is held in wait until it is granted and its transfer completes.
- The arbiter replays the granted transfer on the slave side with clean SETUP/ACCESS phasing, returns the read data and error to that master, and guards against a hung slave with a timeout.

Parameters:
- AW, 12, address width; matches the UART register address width.
- DW, 32, data width.
- TIMEOUT, 16, maximum number of slave ACCESS cycles before the arbiter forces completion with an error. 0 disables the timeout.

Ports:
- pclk_i  in  1  clock
- prst_ni  in  1  asynchronous active-low reset
- m0_psel_i, m0_penable_i, m0_pwrite_i  in  1 each  master 0 APB control
- m0_paddr_i  in  AW  master 0 address
- m0_pwdata_i  in  DW  master 0 write data
- m0_prdata_o  out  DW  master 0 read data
- m0_pready_o, m0_pslverr_o  out  1 each  master 0 completion and error
- m1_* : same set of seven ports as m0_*, for master 1
- s_psel_o, s_penable_o, s_pwrite_o  out  1 each  slave-side APB control
- s_paddr_o  out  AW  slave address
- s_pwdata_o  out  DW  slave write data
- s_prdata_i  in  DW  slave read data
- s_pready_i, s_pslverr_i  in  1 each  slave completion and error
- grant_o  out  2  one-hot owner of the current transfer; 00 when idle

Behaviour:
- Reset is asynchronous, active-low. The clock is pclk_i and the reset is prst_ni. Reset state:
  - FSM in IDLE; last_grant = 1, so master 0 wins the first tie.
  - All s_* outputs are 0, grant_o = 00, timeout counter = 0.
  - All m*_pready_o, m*_pslverr_o and m*_prdata_o are 0.
- Request: req_k = mk_psel_i. Either phase counts.
- FSM states and transitions:
  - IDLE: if any request is present, pick the winner, latch its paddr/pwdata/pwrite into slave-side registers, set grant_o, and go to SETUP. Otherwise stay in IDLE.
  - Winner selection: a single requester wins outright. If both request, the master that is not last_grant wins.
  - SETUP: s_psel_o = 1, s_penable_o = 0. Always go to ACCESS next cycle.
  - ACCESS: s_psel_o = 1, s_penable_o = 1; the counter increments each cycle. Completion occurs when s_pready_i = 1, or when TIMEOUT != 0 and the counter reaches TIMEOUT - 1.
- Completion cycle (combinational, granted master only):
  - mk_pready_o = 1.
  - mk_prdata_o = s_prdata_i, or 0 on timeout.
  - mk_pslverr_o = s_pslverr_i, or 1 on timeout.
  - On the next edge: last_grant = granted index, grant_o = 00, counter cleared, state returns to IDLE.
  - The ungranted master sees pready, prdata and pslverr all 0 throughout.
- Latency:
  - Master psel sampled in IDLE at cycle t gives SETUP at t+1 and ACCESS at t+2.
  - Earliest master pready is at t+2, one cycle per arbitration. Throughput is one transfer per 3 cycles with a zero-wait slave.
- Slave address, data and write are held stable from SETUP through completion and remain unchanged in IDLE. Only psel and penable drop.
- Protocol violation: if the granted master drops psel while waiting, the slave transfer still completes and the result is discarded. There is no abort.
- Back-to-back: in the cycle after completion (IDLE), a pending request from the other master wins over a new request from the same master.
- Reset asserted mid-transfer: everything returns to reset values immediately, and the slave transfer is abandoned.

Decomposition:
- Package uart_arb_pkg contains:
  - arb_state_e {IDLE, SETUP, ACCESS}
  - typedef mst_idx_t (1 bit)
  - the localparam default TIMEOUT
- Sub-module uart_arb_rr_pick: a 2-way round-robin picker.
  - Inputs: req[1:0], last_grant.
  - Outputs: gnt one-hot, valid.
  - Purely combinational and instantiated once.
- The FSM, counter, and data steering live in the top module.

Test Plan:
- Single master 0 write, addr 0x004, data 0x0000_00A5, slave pready = 1 -> s_psel rises at t+1, s_penable at t+2; m0_pready = 1 at t+2; m1_pready stays 0; grant_o = 01 for 2 cycles.
- Both masters request a read in the same cycle after reset -> m0 served first, m1 next. s_prdata 0x11 goes to m0 and 0x22 to m1, with no cross-leakage.
- m0 issues continuous transfers while m1 requests once -> grants alternate 01, 10, 01; m1 completes within 6 cycles of its request.
- Slave holds pready = 0 for 3 ACCESS cycles, then 1 with pslverr = 1 -> master pready asserts exactly once, pslverr = 1, and the address is stable all 4 slave cycles.
- TIMEOUT = 4 and slave pready stuck at 0 -> master pready = 1 with pslverr = 1 and prdata = 0 in the 4th ACCESS cycle; FSM is back in IDLE.
- prst_ni pulsed low during ACCESS -> all outputs 0 asynchronously. After release, the first tie is granted to m0.
